switch_out_port: RTL and testbench

Egress buffer for one switch output port. Takes bytes, each tagged with an end-of-packet flag, from the switch fabric and stores them. Presents only complete packets on the serial output port (`port_out` / `port_ready` / `port_read`), one byte per accepted read. There is one instance per output port, directly upstream of the output-port interface and its monitors.

---
 rtl/switch_pkg.sv | 18 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/switch_out_port.sv | 84 ++++++++
 tb/tb_switch_out_port.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types for the switch egress path: byte width, output FSM states
// and the {last, data} buffer entry.
package switch_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } out_state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular buffer of fifo_entry_t with first-word fall-through read data.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
module sync_fifo
    import switch_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fifo_entry_t      push_dat,
    input  logic             pop,
    output fifo_entry_t      pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/switch_out_port.sv
// Egress buffer for one output port: stores fabric bytes, emits whole packets only.
// Latency: port_ready rises one cycle after the last byte of a packet is written.
// Backpressure: wr_ready drops when full (extra writes dropped, overflow sticks); port_read paces output.
module switch_out_port
    import switch_pkg::*;
#(
    parameter  int DEPTH   = 16,
    parameter  int PORT_ID = 0,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              overflow,
    output logic [BYTE_W-1:0] port_out,
    output logic              port_ready,
    input  logic              port_read,
    output logic [CNT_W-1:0]  pkt_count
);

    out_state_t       state;
    fifo_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] pkt_next;

    assign push       = wr_en && !fifo_full;
    assign pop        = (state == SEND) && port_read;
    assign wr_ready   = !fifo_full;
    assign port_ready = (state == SEND);
    assign port_out   = port_ready ? head.data : '0;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ('{last: wr_last, data: wr_data}),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Write-last and pop-last in the same cycle cancel out.
    always_comb begin
        pkt_next = pkt_count;
        if (push && wr_last)  pkt_next = pkt_next + 1'b1;
        if (pop && head.last) pkt_next = pkt_next - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pkt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            pkt_count <= pkt_next;
            if (wr_en && fifo_full) overflow <= 1'b1;
            case (state)
                IDLE:    if (pkt_count != '0) state <= SEND;
                SEND:    if (pop && head.last) state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A packet in flight must always have its remaining bytes buffered.
    always_ff @(posedge clk) begin
        if (rst_n && state == SEND)
            assert (!fifo_empty && pkt_count <= fifo_count)
                else $error("port %0d: SEND without a buffered packet", PORT_ID);
    end

endmodule

// File: tb/tb_switch_out_port.sv
// Directed bench for switch_out_port: each task drives one scenario and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_switch_out_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_ready;
    logic       overflow;
    logic [7:0] port_out;
    logic       port_ready;
    logic       port_read;
    logic [4:0] pkt_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_out_port #(
        .DEPTH   (16),
        .PORT_ID (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .wr_ready   (wr_ready),
        .overflow   (overflow),
        .port_out   (port_out),
        .port_ready (port_ready),
        .port_read  (port_read),
        .pkt_count  (pkt_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic l);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = l;
        tick();
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0; port_read = 1'b0;
        repeat (3) tick();
        checks++;
        if (port_ready !== 1'b0 || port_out !== 8'h00 || wr_ready !== 1'b1 ||
            overflow !== 1'b0 || pkt_count !== 5'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b out=%h wr_ready=%b ovf=%b pkts=%0d, want 0 00 1 0 0",
                     port_ready, port_out, wr_ready, overflow, pkt_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_packet();
        logic [7:0] exp [3] = '{8'hA1, 8'hB2, 8'hC3};
        port_read = 1'b1;
        write_byte(8'hA1, 1'b0);
        write_byte(8'hB2, 1'b0);
        write_byte(8'hC3, 1'b1);
        checks++;
        if (port_ready !== 1'b0 || pkt_count !== 5'd1) begin
            errors++;
            $display("FAIL basic_e0: rdy=%b pkts=%0d, want 0 1", port_ready, pkt_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (port_ready !== 1'b1 || port_out !== exp[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: rdy=%b out=%h, want 1 %h", i, port_ready, port_out, exp[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (port_ready !== 1'b0 || port_out !== 8'h00 || pkt_count !== 5'd0) begin
                errors++;
                $display("FAIL basic_gap%0d: rdy=%b out=%h pkts=%0d, want 0 00 0", i, port_ready, port_out, pkt_count);
            end
        end
    endtask

    task automatic test_partial_packet();
        logic [7:0] exp [3] = '{8'h55, 8'h66, 8'h77};
        logic       stayed_idle = 1'b1;
        port_read = 1'b1;
        write_byte(8'h55, 1'b0);
        write_byte(8'h66, 1'b0);
        repeat (10) begin
            tick();
            if (port_ready !== 1'b0 || pkt_count !== 5'd0) stayed_idle = 1'b0;
        end
        checks++;
        if (stayed_idle !== 1'b1) begin
            errors++;
            $display("FAIL partial_hold: output started on incomplete packet (rdy=%b pkts=%0d), want 0 0",
                     port_ready, pkt_count);
        end
        write_byte(8'h77, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (port_ready !== 1'b1 || port_out !== exp[i]) begin
                errors++;
                $display("FAIL partial_byte%0d: rdy=%b out=%h, want 1 %h", i, port_ready, port_out, exp[i]);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_fill_overflow();
        int         got = 0;
        logic [7:0] want;
        port_read = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i), (i % 4) == 3);
        checks++;
        if (wr_ready !== 1'b0 || pkt_count !== 5'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: wr_ready=%b pkts=%0d ovf=%b, want 0 4 0", wr_ready, pkt_count, overflow);
        end
        write_byte(8'hEE, 1'b1);
        checks++;
        if (overflow !== 1'b1 || pkt_count !== 5'd4) begin
            errors++;
            $display("FAIL fill_overflow: ovf=%b pkts=%0d, want 1 4", overflow, pkt_count);
        end
        port_read = 1'b1;
        for (int c = 0; c < 60 && got < 16; c++) begin
            if (port_ready === 1'b1) begin
                want = 8'h20 + 8'(got);
                checks++;
                if (port_out !== want) begin
                    errors++;
                    $display("FAIL drain_byte%0d: out=%h, want %h", got, port_out, want);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got !== 16 || pkt_count !== 5'd0 || wr_ready !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: bytes=%0d pkts=%0d wr_ready=%b ovf=%b, want 16 0 1 1",
                     got, pkt_count, wr_ready, overflow);
        end
        repeat (2) tick();
    endtask

    task automatic test_read_toggle();
        logic       rd  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp [7] = '{8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13, 8'h00};
        port_read = 1'b0;
        write_byte(8'h10, 1'b0);
        write_byte(8'h11, 1'b0);
        write_byte(8'h12, 1'b0);
        write_byte(8'h13, 1'b1);
        tick();
        checks++;
        if (port_ready !== 1'b1 || port_out !== 8'h10) begin
            errors++;
            $display("FAIL toggle_first: rdy=%b out=%h, want 1 10", port_ready, port_out);
        end
        for (int i = 0; i < 7; i++) begin
            port_read = rd[i];
            tick();
            checks++;
            if (port_out !== exp[i] || port_ready !== (i < 6)) begin
                errors++;
                $display("FAIL toggle_step%0d: rdy=%b out=%h, want %b %h", i, port_ready, port_out, i < 6, exp[i]);
            end
        end
        port_read = 1'b0;
        tick();
    endtask

    task automatic test_concurrent();
        port_read = 1'b0;
        write_byte(8'h40, 1'b0);
        write_byte(8'h41, 1'b1);
        tick();
        port_read = 1'b1;
        tick();
        checks++;
        if (port_out !== 8'h41 || pkt_count !== 5'd1 || dut.u_fifo.count !== 5'd1) begin
            errors++;
            $display("FAIL conc_pre: out=%h pkts=%0d occ=%0d, want 41 1 1", port_out, pkt_count, dut.u_fifo.count);
        end
        write_byte(8'h50, 1'b1);
        checks++;
        if (pkt_count !== 5'd1 || dut.u_fifo.count !== 5'd1 || port_ready !== 1'b0) begin
            errors++;
            $display("FAIL conc_same: pkts=%0d occ=%0d rdy=%b, want 1 1 0", pkt_count, dut.u_fifo.count, port_ready);
        end
        repeat (2) tick();
        checks++;
        if (port_ready !== 1'b1 || port_out !== 8'h50) begin
            errors++;
            $display("FAIL conc_next: rdy=%b out=%h, want 1 50", port_ready, port_out);
        end
        tick();
        checks++;
        if (port_ready !== 1'b0 || pkt_count !== 5'd0) begin
            errors++;
            $display("FAIL conc_done: rdy=%b pkts=%0d, want 0 0", port_ready, pkt_count);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_packet();
        port_read = 1'b1;
        write_byte(8'h60, 1'b0);
        write_byte(8'h61, 1'b0);
        write_byte(8'h62, 1'b0);
        write_byte(8'h63, 1'b1);
        tick();
        tick();
        checks++;
        if (port_ready !== 1'b1 || port_out !== 8'h61) begin
            errors++;
            $display("FAIL midrst_pre: rdy=%b out=%h, want 1 61", port_ready, port_out);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (port_ready !== 1'b0 || port_out !== 8'h00 || pkt_count !== 5'd0 ||
            wr_ready !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst: rdy=%b out=%h pkts=%0d wr_ready=%b ovf=%b, want 0 00 0 1 0",
                     port_ready, port_out, pkt_count, wr_ready, overflow);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (port_ready !== 1'b0 || dut.u_fifo.count !== 5'd0) begin
            errors++;
            $display("FAIL midrst_after: rdy=%b occ=%0d, want 0 0", port_ready, dut.u_fifo.count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_partial_packet();
        test_fill_overflow();
        test_read_toggle();
        test_concurrent();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
